// File: rtl/twophase_fifo_stage.sv
// Clocked FIFO stage between two 2-phase (transition-signalled) bundled-data channels.
// Define MOUSETRAP_SYNC_EN to pass req_in and ack_out through SYNC_STAGES-flop synchronisers.
module twophase_fifo_stage #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_in,
    input  logic [WORD_WIDTH-1:0]        Data_in,
    output logic                         ack_in,
    output logic                         req_out,
    output logic [WORD_WIDTH-1:0]        Data_out,
    input  logic                         ack_out,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} rd_state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2) begin : g_param_check
        $error("twophase_fifo_stage: DEPTH must be a power of two >= 2 and SYNC_STAGES >= 2");
    end

    logic                  w_req_s;
    logic                  w_ack_s;
    logic                  w_wr_en;
    logic                  w_launch;
    logic                  w_retire;
    rd_state_t             w_state_nxt;
    logic [OCC_W-1:0]      w_occ_nxt;

    rd_state_t             r_state;
    logic                  r_ack_in;
    logic                  r_req_out;
    logic [WORD_WIDTH-1:0] r_data_out;
    logic [OCC_W-1:0]      r_occ;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

`ifdef MOUSETRAP_SYNC_EN
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;

    // Synchronise the incoming request and acknowledge phases into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_sync <= {SYNC_STAGES{1'b0}};
            r_ack_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_in};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_out};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
`else
    assign w_req_s = req_in;
    assign w_ack_s = ack_out;
`endif

    // Occupancy (not pointer equality) decides full, so the pointers may wrap freely.
    assign w_wr_en = (w_req_s != r_ack_in) && (r_occ < OCC_FULL);

    // Read-side FSM: launch from registered occupancy only, so no same-edge bypass.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_occ != OCC_ZERO) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_ack_s == r_req_out) begin
                    w_retire = 1'b1;
                    if (r_occ > OCC_ONE) begin
                        w_launch    = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next occupancy: a write and a retire on the same edge cancel out.
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_wr_en && !w_retire) begin
            w_occ_nxt = r_occ + OCC_ONE;
        end else if (!w_wr_en && w_retire) begin
            w_occ_nxt = r_occ - OCC_ONE;
        end else begin
            w_occ_nxt = r_occ;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ack_in   <= 1'b0;
            r_req_out  <= 1'b0;
            r_data_out <= {WORD_WIDTH{1'b0}};
            r_occ      <= OCC_ZERO;
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            if (w_wr_en) begin
                r_ack_in <= ~r_ack_in;
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_launch) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_req_out  <= ~r_req_out;
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage array; stale contents are unreachable after reset because the pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= Data_in;
        end
    end

    assign ack_in    = r_ack_in;
    assign req_out   = r_req_out;
    assign Data_out  = r_data_out;
    assign occupancy = r_occ;

endmodule
